// File: rtl/freq_synth.sv
// Programmable square-wave source: 4-digit BCD setpoint (optionally x10) drives a
// phase accumulator that toggles `signal` at exactly twice the requested frequency.
module freq_synth #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned ACC_W  = 28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bcd_in,
  input  logic        range,
  input  logic        load,
  output logic        ready,
  output logic        err,
  output logic [19:0] freq_hz,
  output logic        signal
);

  typedef enum logic [1:0] {StIdle, StConv, StRun} state_e;

  localparam logic [ACC_W:0]   ModWide = (ACC_W+1)'(CLK_HZ);
  localparam logic [ACC_W-1:0] ModAcc  = ACC_W'(CLK_HZ);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             range_q, range_d;
  logic             err_q, err_d;
  logic [19:0]      freq_q, freq_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sig_q, sig_d;

  logic             bcd_ok;
  logic [3:0]       digit;
  logic [13:0]      bin_next;
  logic [19:0]      bin_final;
  logic [20:0]      dbl;
  logic [ACC_W-1:0] step;
  logic [ACC_W:0]   sum;

  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
    end
  end

  // Most significant digit is consumed first.
  always_comb begin
    unique case (cnt_q)
      2'd0:    digit = bcd_q[15:12];
      2'd1:    digit = bcd_q[11:8];
      2'd2:    digit = bcd_q[7:4];
      default: digit = bcd_q[3:0];
    endcase
  end

  assign bin_next  = bin_q * 14'd10 + {10'd0, digit};
  assign bin_final = {6'd0, bin_next};

  // Step saturates at the modulus, which makes the output toggle every clock.
  always_comb begin
    dbl = {freq_q, 1'b0};
    if ({11'd0, dbl} > CLK_HZ) step = ModAcc;
    else                       step = ACC_W'(dbl);
    sum = {1'b0, acc_q} + {1'b0, step};
  end

  // Accumulator runs in every state; a zero step (IDLE) can never wrap since acc < CLK_HZ.
  always_comb begin
    if (sum >= ModWide) begin
      acc_d = acc_q + step - ModAcc;
      sig_d = ~sig_q;
    end else begin
      acc_d = sum[ACC_W-1:0];
      sig_d = sig_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    range_d = range_q;
    err_d   = err_q;
    freq_d  = freq_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (load) begin
          if (bcd_ok) begin
            err_d   = 1'b0;
            bcd_d   = bcd_in;
            range_d = range;
            bin_d   = '0;
            cnt_d   = '0;
            state_d = StConv;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StConv: begin
        bin_d = bin_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          freq_d  = range_q ? bin_final * 20'd10 : bin_final;
          state_d = (bin_next == 14'd0) ? StIdle : StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      range_q <= 1'b0;
      err_q   <= 1'b0;
      freq_q  <= '0;
      acc_q   <= '0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      range_q <= range_d;
      err_q   <= err_d;
      freq_q  <= freq_d;
      acc_q   <= acc_d;
      sig_q   <= sig_d;
    end
  end

  assign ready   = (state_q != StConv);
  assign err     = err_q;
  assign freq_hz = freq_q;
  assign signal  = sig_q;

endmodule
